// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready and out_valid are registered so no combinational path crosses the stage.
module pipe_stage_skid_reg #(
  parameter int unsigned      WIDTH        = 171,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = '0
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam int unsigned OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] s_q;
  logic             accept;
  logic             pop;

  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign out_data = m_q;

  // State, storage and the handshake flags move together so every output is a flop.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= EMPTY;
      m_q       <= BUBBLE_VALUE;
      s_q       <= BUBBLE_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= OCC_W'(0);
    end else if (flush) begin
      state     <= EMPTY;
      m_q       <= BUBBLE_VALUE;
      s_q       <= BUBBLE_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= OCC_W'(0);
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_q       <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
            occupancy <= OCC_W'(1);
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_q <= in_data;
          end else if (accept) begin
            // Downstream stalled this cycle: park the word in the skid entry.
            s_q       <= in_data;
            state     <= TWO;
            in_ready  <= 1'b0;
            occupancy <= OCC_W'(2);
          end else if (pop) begin
            m_q       <= BUBBLE_VALUE;
            state     <= EMPTY;
            out_valid <= 1'b0;
            occupancy <= OCC_W'(0);
          end
        end
        TWO: begin
          if (pop) begin
            m_q       <= s_q;
            s_q       <= BUBBLE_VALUE;
            state     <= ONE;
            in_ready  <= 1'b1;
            occupancy <= OCC_W'(1);
          end
        end
        default: begin
          state     <= EMPTY;
          m_q       <= BUBBLE_VALUE;
          s_q       <= BUBBLE_VALUE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          occupancy <= OCC_W'(0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a wide instance and a 1-bit instance share stimulus.
// The driver logs accepted words; the monitor retires them as the stage hands them out.
module tb_pipe_stage_skid_reg;

  localparam int unsigned W = 171;
  localparam logic [W-1:0] BUB = {1'b1, 170'h0BAD_F00D_CAFE};

  logic         clk = 1'b0;
  logic         areset_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;
  logic         in_ready1, out_valid1;
  logic [0:0]   out_data1;
  logic [1:0]   occupancy1;

  logic [W-1:0] exp_q[$];
  int           rd_ptr = 0;
  bit           mdl_rdy = 1'b1;
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_d;
  logic         exp_d1;
  int           occ;

  pipe_stage_skid_reg #(.WIDTH(W), .BUBBLE_VALUE(BUB)) dut (
    .clk(clk), .areset_n(areset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid_reg #(.WIDTH(1), .BUBBLE_VALUE(1'b1)) dut1 (
    .clk(clk), .areset_n(areset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data[0:0]),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle against the scoreboard, retire words on downstream pops.
  always begin
    @(negedge clk);
    #1;
    if (!areset_n) rd_ptr = exp_q.size();
    occ     = exp_q.size() - rd_ptr;
    exp_d   = (occ > 0) ? exp_q[rd_ptr] : BUB;
    exp_d1  = (occ > 0) ? exp_d[0] : 1'b1;
    mdl_rdy = (occ < 2);
    chk("out_valid",  W'(out_valid),  W'(occ > 0));
    chk("in_ready",   W'(in_ready),   W'(occ < 2));
    chk("occupancy",  W'(occupancy),  W'(occ));
    chk("out_data",   out_data,       exp_d);
    chk("w1_valid",   W'(out_valid1), W'(occ > 0));
    chk("w1_ready",   W'(in_ready1),  W'(occ < 2));
    chk("w1_occ",     W'(occupancy1), W'(occ));
    chk("w1_data",    W'(out_data1),  W'(exp_d1));
    if (areset_n) begin
      if (flush) begin
        rd_ptr = exp_q.size();
      end else if (out_ready && occ > 0) begin
        chk("pop_data", out_data, exp_q[rd_ptr]);
        rd_ptr++;
      end
    end
  end

  // Driver: present one cycle of stimulus and log the word if the stage will take it.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit f);
    @(negedge clk);
    in_valid  = v;
    in_data   = v ? d : 'x;
    out_ready = r;
    flush     = f;
    #2;
    if (areset_n && !f && v && mdl_rdy) exp_q.push_back(d);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst0_valid", W'(out_valid), W'(1'b0));
    chk("rst0_ready", W'(in_ready),  W'(1'b1));
    chk("rst0_occ",   W'(occupancy), W'(0));
    chk("rst0_data",  out_data,      BUB);
    @(negedge clk);
    areset_n = 1'b1;

    // Streaming at full rate
    for (int i = 1; i <= 20; i++) drive(1'b1, W'(i), 1'b1, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A visible, B skids, C held upstream
    drive(1'b1, W'(32'hA), 1'b1, 1'b0);
    drive(1'b1, W'(32'hB), 1'b0, 1'b0);
    drive(1'b1, W'(32'hC), 1'b0, 1'b0);
    chk("bp_occ",   W'(occupancy), W'(2));
    chk("bp_ready", W'(in_ready),  W'(1'b0));
    chk("bp_m",     out_data,      W'(32'hA));
    drive(1'b1, W'(32'hC), 1'b0, 1'b0);
    drive(1'b1, W'(32'hC), 1'b1, 1'b0);
    drive(1'b1, W'(32'hC), 1'b1, 1'b0);
    chk("bp_second", out_data, W'(32'hB));
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_third", out_data, W'(32'hC));
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_idle", out_data, BUB);

    // Flush with both entries full and a word offered
    drive(1'b1, W'(5), 1'b1, 1'b0);
    drive(1'b1, W'(6), 1'b0, 1'b0);
    drive(1'b1, W'(7), 1'b0, 1'b1);
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("fl_occ",   W'(occupancy), W'(0));
    chk("fl_valid", W'(out_valid), W'(1'b0));
    chk("fl_data",  out_data,      BUB);
    chk("fl_w1",    W'(out_data1), W'(1'b1));
    repeat (2) drive(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset with two entries held
    drive(1'b1, W'(32'h11), 1'b1, 1'b0);
    drive(1'b1, W'(32'h22), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_occ", W'(occupancy), W'(2));
    #3;
    areset_n = 1'b0;
    #1;
    chk("arst_valid", W'(out_valid), W'(1'b0));
    chk("arst_ready", W'(in_ready),  W'(1'b1));
    chk("arst_occ",   W'(occupancy), W'(0));
    chk("arst_data",  out_data,      BUB);
    chk("arst_w1",    W'(out_data1), W'(1'b1));
    drive(1'b1, W'(32'h33), 1'b1, 1'b0);
    @(negedge clk);
    areset_n = 1'b1;
    in_valid = 1'b0;

    // Random traffic with occasional flush
    for (int n = 0; n < 10000; n++) begin
      drive(1'($urandom_range(0, 1)),
            W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}),
            1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 9) == 0));
    end
    repeat (4) drive(1'b0, '0, 1'b1, 1'b0);
    chk("end_data", out_data,      BUB);
    chk("end_occ",  W'(occupancy), W'(0));
    chk("end_w1",   W'(out_data1), W'(1'b1));

    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
